// File: rtl/lcd_glyph_engine.sv
// rtl/lcd_glyph_engine.sv - tick-timed HD44780 controller rendering custom-glyph tiles from an external glyph ROM
module lcd_glyph_engine #(
  parameter int STEP_TICKS    = 100000,
  parameter int POWER_STEPS   = 4,
  parameter int NUM_SLOTS     = 2,
  parameter int TILE_COLS     = 2,
  parameter int SLOT_PITCH    = 4,
  parameter int COL0          = 0,
  parameter int SEL_W         = 3,
  parameter int REFRESH_STEPS = 25
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_SLOTS*SEL_W-1:0]               sel,
  input  logic                                     update_req,
  output logic                                     busy,
  output logic [SEL_W+$clog2(2*TILE_COLS)+2:0]     rom_addr,
  input  logic [7:0]                               rom_data,
  output logic                                     lcd_rs,
  output logic                                     lcd_rw,
  output logic                                     lcd_en,
  output logic [7:0]                               lcd_data
);
  localparam int TW     = $clog2(STEP_TICKS);
  localparam int GW     = $clog2(2*TILE_COLS);
  localparam int AW     = SEL_W + GW + 3;
  localparam int NCH    = NUM_SLOTS * TILE_COLS * 2;
  localparam int NBYTES = NCH * 8;
  localparam int NW     = $clog2(NBYTES);
  localparam int KW     = $clog2(NCH);

  typedef enum logic [2:0] {POWER_WAIT, INIT, IDLE, CG_ADDR, CG_DATA, POS, CHAR} state_t;

  state_t                      state;
  logic [TW-1:0]               tick;
  logic [15:0]                 cnt;
  logic [NW-1:0]               nb;
  logic [KW-1:0]               kc;
  logic [NUM_SLOTS*SEL_W-1:0]  sel_q;
  logic                        pending;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Byte nb of the CGRAM stream: glyph nb/8 of its slot's figure, bitmap line nb%8.
  function automatic logic [AW-1:0] addr_of(input logic [NUM_SLOTS*SEL_W-1:0] sv, input int n);
    logic [NUM_SLOTS*SEL_W-1:0] sh;
    int kk;
    kk = n / 8;
    sh = sv >> ((kk / (2*TILE_COLS)) * SEL_W);
    if (n >= NBYTES) return '0;
    return {sh[SEL_W-1:0], GW'(kk % (2*TILE_COLS)), 3'(n % 8)};
  endfunction

  function automatic logic [7:0] pos_of(input int k);
    int s, rem;
    s   = k / (2*TILE_COLS);
    rem = k % (2*TILE_COLS);
    return 8'(128 + 64*(rem / TILE_COLS) + COL0 + s*SLOT_PITCH + rem % TILE_COLS);
  endfunction

  logic          step_end, refresh_due, start, do_load, strobe_st, en_win;
  logic [TW:0]   tick_nx;
  logic          unused_rom_bits;

  assign lcd_rw          = 1'b0;
  assign unused_rom_bits = ^rom_data[7:5];
  assign step_end        = (tick == TW'(STEP_TICKS-1));
  assign refresh_due     = (REFRESH_STEPS != 0) && (cnt == 16'(REFRESH_STEPS-1));
  assign start           = update_req | pending | (sel != sel_q) | refresh_due;
  assign strobe_st       = state inside {INIT, CG_ADDR, CG_DATA, POS, CHAR};
  assign tick_nx         = {1'b0, tick} + (TW+1)'(1);
  assign en_win          = (tick_nx >= (TW+1)'(STEP_TICKS/4)) && (tick_nx < (TW+1)'(3*STEP_TICKS/4));
  // Loading is folded into the step boundary, so CG_ADDR begins on the edge that latches sel.
  assign do_load         = step_end && ((state == INIT && cnt == 16'd3) || (state == IDLE && start));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= POWER_WAIT;
      tick     <= '0;
      cnt      <= '0;
      nb       <= '0;
      kc       <= '0;
      sel_q    <= '0;
      pending  <= 1'b0;
      busy     <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= 8'h00;
      rom_addr <= '0;
    end else begin
      lcd_en  <= strobe_st && en_win;
      tick    <= step_end ? '0 : tick + TW'(1);
      pending <= pending | update_req | (sel != sel_q);
      if (step_end) begin
        case (state)
          POWER_WAIT: begin
            if (cnt == 16'(POWER_STEPS-1)) begin
              state    <= INIT;
              cnt      <= '0;
              lcd_rs   <= 1'b0;
              lcd_data <= init_cmd(2'd0);
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          INIT: begin
            if (cnt != 16'd3) begin
              cnt      <= cnt + 16'd1;
              lcd_data <= init_cmd(cnt[1:0] + 2'd1);
            end
          end
          IDLE: begin
            if (!start && REFRESH_STEPS != 0) cnt <= cnt + 16'd1;
          end
          CG_ADDR: begin
            state    <= CG_DATA;
            lcd_rs   <= 1'b1;
            lcd_data <= {3'b000, rom_data[4:0]};
            rom_addr <= addr_of(sel_q, 1);
          end
          CG_DATA: begin
            if (nb == NW'(NBYTES-1)) begin
              state    <= POS;
              kc       <= '0;
              lcd_rs   <= 1'b0;
              lcd_data <= pos_of(0);
            end else begin
              nb       <= nb + NW'(1);
              lcd_data <= {3'b000, rom_data[4:0]};
              rom_addr <= addr_of(sel_q, 32'(nb) + 2);
            end
          end
          POS: begin
            state    <= CHAR;
            lcd_rs   <= 1'b1;
            lcd_data <= 8'(kc);
          end
          CHAR: begin
            if (kc == KW'(NCH-1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              kc       <= kc + KW'(1);
              state    <= POS;
              lcd_rs   <= 1'b0;
              lcd_data <= pos_of(32'(kc) + 1);
            end
          end
          default: state <= POWER_WAIT;
        endcase
      end
      if (do_load) begin
        state    <= CG_ADDR;
        sel_q    <= sel;
        pending  <= 1'b0;
        busy     <= 1'b1;
        cnt      <= '0;
        nb       <= '0;
        lcd_rs   <= 1'b0;
        lcd_data <= 8'h40;
        rom_addr <= addr_of(sel, 0);
      end
    end
  end
endmodule

// File: tb/tb_lcd_glyph_engine.sv
// tb/tb_lcd_glyph_engine.sv - directed bench for lcd_glyph_engine with STEP_TICKS=8
module tb_lcd_glyph_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b0, reset2 = 1'b0;
  logic [5:0] sel = {3'd5, 3'd2};
  logic [5:0] sel2 = {3'd5, 3'd2};
  logic       update_req = 1'b0, update_req2 = 1'b0;
  logic       busy, busy2;
  logic [7:0] rom_addr, rom_addr2, rom_data = 8'h00, rom_data2 = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_rs2, lcd_rw2, lcd_en2;
  logic [7:0] lcd_data, lcd_data2;

  int total = 0;
  int bad = 0;
  int pcnt = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       chk_a;
    logic [7:0] addr;
  } exp_t;
  exp_t exp_q[$];

  lcd_glyph_engine #(.STEP_TICKS(8), .REFRESH_STEPS(0)) dut (
    .clk(clk), .reset(reset), .sel(sel), .update_req(update_req), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data(lcd_data));

  lcd_glyph_engine #(.STEP_TICKS(8), .REFRESH_STEPS(3)) dut2 (
    .clk(clk), .reset(reset2), .sel(sel2), .update_req(update_req2), .busy(busy2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2),
    .lcd_en(lcd_en2), .lcd_data(lcd_data2));

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;
  always @(posedge clk) rom_data <= rom_addr;
  always @(posedge clk) rom_data2 <= rom_addr2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back('{1'b0, 8'h38, 1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'h0C, 1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'h06, 1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'h01, 1'b0, 8'h00});
  endtask

  // ROM echoes its address, so byte n shows {glyph, line} = n%32 and the figure only in rom_addr.
  task automatic push_refresh(input logic [2:0] f0, input logic [2:0] f1);
    logic [7:0] pc [16];
    pc = '{8'h80, 8'h00, 8'h81, 8'h01, 8'hC0, 8'h02, 8'hC1, 8'h03,
           8'h84, 8'h04, 8'h85, 8'h05, 8'hC4, 8'h06, 8'hC5, 8'h07};
    exp_q.push_back('{1'b0, 8'h40, 1'b1, {f0, 5'd0}});
    for (int n = 0; n < 64; n++)
      exp_q.push_back('{1'b1, 8'(n % 32), (n < 63), {((n + 1) < 32) ? f0 : f1, 5'(n + 1)}});
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{1'(i % 2), pc[i], 1'b0, 8'h00});
  endtask

  task automatic wait_busy(input bit which, input logic lvl, input int limit, output int t);
    int n = 0;
    while (((which ? busy2 : busy) !== lvl) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("wait_busy_timeout", 0, 1);
    t = pcnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rs"}, lcd_rs, 0);
    check({tag, "_rw"}, lcd_rw, 0);
    check({tag, "_en"}, lcd_en, 0);
    check({tag, "_data"}, lcd_data, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  logic       en_prev = 1'b0;
  logic       stable;
  logic       s_rs;
  logic [7:0] s_data;
  int         hi;
  always @(negedge clk) begin
    if (!reset) begin
      en_prev = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        if (exp_q.size() == 0) begin
          check("extra_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_rs", lcd_rs, e.rs);
          check("strobe_data", lcd_data, e.data);
          if (e.chk_a) check("strobe_rom_addr", rom_addr, e.addr);
        end
        s_rs = lcd_rs; s_data = lcd_data; hi = 1; stable = 1'b1;
      end else if (lcd_en) begin
        hi++;
        if (lcd_rs !== s_rs || lcd_data !== s_data) stable = 1'b0;
      end else if (en_prev) begin
        check("en_width", hi, 4);
        check("en_stable", stable, 1);
      end
      en_prev = lcd_en;
    end
  end

  initial begin
    int t0, t1, t2, t3, n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    push_init();
    push_refresh(3'd2, 3'd5);
    reset = 1'b1;
    t0 = pcnt;
    n = 0;
    while (!lcd_en && n < 200) begin @(negedge clk); n++; end
    check("first_strobe_cyc", pcnt - t0, 34);
    wait_busy(0, 1'b0, 2000, t1);
    check("powerup_busy_fall", t1 - t0, 712);
    check("powerup_strobes_left", exp_q.size(), 0);

    repeat (40) @(negedge clk);
    check("idle_persists", busy, 0);

    push_refresh(3'd2, 3'd5);
    t0 = pcnt;
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    wait_busy(0, 1'b1, 100, t1);
    check("req_to_busy", t1 - t0, 8);

    repeat (160) @(negedge clk);
    sel = {3'd1, 3'd6};
    push_refresh(3'd6, 3'd1);
    repeat (8) @(negedge clk);
    update_req = 1'b1; @(negedge clk); update_req = 1'b0;
    repeat (8) @(negedge clk);
    update_req = 1'b1; @(negedge clk); update_req = 1'b0;
    wait_busy(0, 1'b0, 1000, t2);
    check("refresh_len", t2 - t1, 648);
    check("old_sel_refresh_left", exp_q.size(), 81);
    wait_busy(0, 1'b1, 100, t3);
    check("pending_gap", t3 - t2, 8);
    wait_busy(0, 1'b0, 1000, t2);
    check("extra_refresh_len", t2 - t3, 648);
    check("extra_strobes_left", exp_q.size(), 0);
    repeat (200) @(negedge clk);
    check("one_extra_only", busy, 0);

    push_refresh(3'd6, 3'd1);
    update_req = 1'b1; @(negedge clk); update_req = 1'b0;
    wait_busy(0, 1'b1, 100, t1);
    repeat (8*76 - (pcnt - t1) + 1) @(negedge clk);
    check("pre_reset_left", exp_q.size(), 5);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    exp_q.delete();
    push_init();
    push_refresh(3'd6, 3'd1);
    @(negedge clk);
    reset = 1'b1;
    t0 = pcnt;
    wait_busy(0, 1'b0, 2000, t1);
    check("reinit_busy_fall", t1 - t0, 712);
    check("reinit_strobes_left", exp_q.size(), 0);

    reset2 = 1'b1;
    t0 = pcnt;
    wait_busy(1, 1'b0, 2000, t1);
    check("auto_first_fall", t1 - t0, 712);
    wait_busy(1, 1'b1, 200, t2);
    check("auto_idle_gap", t2 - t1, 24);
    wait_busy(1, 1'b0, 1000, t3);
    check("auto_refresh_len", t3 - t2, 648);
    wait_busy(1, 1'b1, 200, t2);
    check("auto_idle_gap2", t2 - t3, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_glyph_engine.md
# lcd_glyph_engine

Parametrised HD44780-class character-LCD controller that renders NUM_SLOTS custom-glyph tiles side by side. Each slot shows one figure chosen by a per-slot select field. Glyph bitmaps are fetched from an external synchronous ROM. The block replaces free-running enable-as-clock drive with a tick-timed enable strobe, and adds a busy handshake, refresh on select change or request, and a periodic auto-refresh. It sits between the game-state logic (figure selects) and the LCD pins.

## Interface
- STEP_TICKS, 100000: clk cycles per LCD bus step, ≥ 8, multiple of 4.
- POWER_STEPS, 4: idle steps after reset before init.
- NUM_SLOTS, 2: figures on screen.
- TILE_COLS, 2: character columns per tile. Tile height is fixed at 2 rows. NUM_SLOTS·TILE_COLS·2 ≤ 8 (CGRAM capacity).
- SLOT_PITCH, 4: DDRAM column distance between slot origins.
- COL0, 0: DDRAM column of slot 0.
- SEL_W, 3: figure index width per slot.
- REFRESH_STEPS, 25: idle steps before auto-refresh; 0 disables auto-refresh.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- sel  in  NUM_SLOTS·SEL_W  figure index per slot; slot 0 in the LSBs.
- update_req  in  1  single-cycle refresh request.
- busy  out  1  high while not in IDLE.
- rom_addr  out  SEL_W+clog2(2·TILE_COLS)+3  address {fig, glyph, line}.
- rom_data  in  8  bitmap row; 1-cycle read latency; bits [4:0] are used.
- lcd_rs, lcd_rw, lcd_en  out  1  LCD control.
- lcd_data  out  8  LCD bus.

## Operation
- Reset values (next edge with reset=0): lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0, rom_addr=0, busy=1. State POWER_WAIT, all counters 0, pending=0.
- lcd_rw is tied to 0. The block never reads the LCD.
- States:
  - POWER_WAIT → INIT after POWER_STEPS steps.
  - INIT sends 0x38, 0x0C, 0x06, 0x01 (rs=0), one per step, then goes to LOAD.
  - IDLE.
  - LOAD latches sel into sel_q, clears pending, takes 0 steps, then CG_ADDR.
  - CG_ADDR sends 0x40 (rs=0).
  - CG_DATA sends NUM_SLOTS·TILE_COLS·2·8 bytes (rs=1), relying on CGRAM auto-increment.
  - POS / CHAR alternate for each of the NUM_SLOTS·TILE_COLS·2 characters.
  - After the last CHAR the block returns to IDLE.
- Char index k = s·2·TILE_COLS + r·TILE_COLS + c, where s is the slot, r is the tile row (0..1) and c is the tile column.
- CG_DATA byte n: glyph k = n/8, line = n%8. rom_addr = {sel_q[s], r·TILE_COLS+c, line}. lcd_data = {3'b000, rom_data[4:0]}.
- POS sends 0x80 + 0x40·r + COL0 + s·SLOT_PITCH + c (rs=0). CHAR sends 0x00+k (rs=1).
- Order: slot-major, then row, then column.
- IDLE exits to LOAD on any of:
  - update_req;
  - sel ≠ sel_q;
  - pending;
  - idle step counter reaching REFRESH_STEPS (counter clears on exit).
- update_req or a sel change while busy sets pending. Exactly one extra refresh follows the current one. A refresh in progress is never aborted or torn: it uses sel_q throughout.
- Reset mid-operation returns to POWER_WAIT and repeats full init.

## Timing
- Tick counter t runs 0..STEP_TICKS-1. A step ends at t=STEP_TICKS-1 and the state advances there.
- lcd_rs and lcd_data change only on the cycle t=0 and are stable for the whole step.
- lcd_en=1 for STEP_TICKS/4 ≤ t < 3·STEP_TICKS/4, otherwise 0. Exactly one strobe per step in INIT/CG_ADDR/CG_DATA/POS/CHAR. No strobe in POWER_WAIT or IDLE.
- rom_addr for a byte is driven one full step before that byte's step (during CG_ADDR for byte 0). rom_data is captured at t=STEP_TICKS-1.
- Refresh length = 1 + 16·NUM_SLOTS·TILE_COLS + 4·NUM_SLOTS·TILE_COLS steps. This is 81 steps at defaults. busy rises the cycle LOAD is entered and falls the cycle IDLE is entered.
- First strobe (0x38) occurs in step POWER_STEPS after reset release.

## Test plan
- Power-up, STEP_TICKS=8, defaults → strobes carry 0x38,0x0C,0x06,0x01,0x40, then 64 ROM bytes, then 0x80,0x00,0x81,0x01,0xC0,0x02,0xC1,0x03,0x84,0x04,… ending 0xC5,0x07. busy falls after 4+4+81 steps.
- ROM model returning addr[7:0], sel={3'd5,3'd2} → CG_DATA bytes 0–31 carry the figure-2 addresses and bytes 32–63 carry the figure-5 addresses, low 5 bits only.
- Change sel mid-CG_DATA → current refresh completes unchanged using the old sel_q. Exactly one further 81-step refresh then runs with the new sel.
- update_req pulse in IDLE → busy next step boundary path. Two pulses while busy → only one extra refresh.
- REFRESH_STEPS=3, no stimulus → refresh starts 3 idle steps after each completion. With REFRESH_STEPS=0, IDLE persists indefinitely.
- Assert reset during CHAR step → next cycle all outputs are 0 and busy=1. The full init sequence repeats. Every lcd_en pulse lasts STEP_TICKS/2 cycles, with rs/data stable across it.
